// File: rtl/mmio_pkg.sv
// Register map and defaults shared by the MMIO LED controller and its blink timer.
package mmio_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  localparam logic [4:0] OFF_OUT        = 5'h00;
  localparam logic [4:0] OFF_SET        = 5'h04;
  localparam logic [4:0] OFF_CLR        = 5'h08;
  localparam logic [4:0] OFF_TOG        = 5'h0C;
  localparam logic [4:0] OFF_BLINK_MASK = 5'h10;
  localparam logic [4:0] OFF_PERIOD     = 5'h14;
  localparam logic [4:0] OFF_COUNT      = 5'h18;

  typedef enum logic [2:0] {
    REG_OUT        = OFF_OUT[4:2],
    REG_SET        = OFF_SET[4:2],
    REG_CLR        = OFF_CLR[4:2],
    REG_TOG        = OFF_TOG[4:2],
    REG_BLINK_MASK = OFF_BLINK_MASK[4:2],
    REG_PERIOD     = OFF_PERIOD[4:2],
    REG_COUNT      = OFF_COUNT[4:2],
    REG_RSVD       = 3'd7
  } reg_sel_t;

  function automatic reg_sel_t reg_sel(input logic [31:0] byte_addr);
    return reg_sel_t'(byte_addr[4:2]);
  endfunction

endpackage

// File: rtl/mmio_led_ctrl_blink_timer.sv
// Free-running blink counter: counts 0..period and pulses tick on the wrap cycle.
// period==0 parks the counter at 0; clear (a PERIOD store) restarts it and swallows that cycle's tick.
module blink_timer #(
  parameter int CNT_W = 24
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] period,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  logic [CNT_W-1:0] count_q;
  logic             at_end;

  assign at_end = (period != '0) && (count_q == period);
  assign tick   = at_end && !clear && !reset;
  assign count  = count_q;

  always_ff @(posedge sys_clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (period == '0 || at_end) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mmio_led_ctrl.sv
// Memory-mapped LED controller: OUT/SET/CLR/TOG access plus periodic hardware blink.
// Decode and read data are combinational; all register updates land on the store edge.
module mmio_led_ctrl
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          NUM_LEDS  = 1,
  parameter int          CNT_W     = 24
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                mem_write,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic                hit,
  output logic [31:0]         rdata,
  output logic [NUM_LEDS-1:0] led
);

  logic [NUM_LEDS-1:0] out_q;
  logic [NUM_LEDS-1:0] out_next;
  logic [NUM_LEDS-1:0] mask_q;
  logic [NUM_LEDS-1:0] wr_bits;
  logic [CNT_W-1:0]    period_q;
  logic [CNT_W-1:0]    count;
  logic                tick;
  logic                wr;
  logic                period_wr;
  reg_sel_t            sel;
  logic                unused;

  assign hit       = (addr[31:5] == BASE_ADDR[31:5]);
  assign wr        = mem_write && hit;
  assign sel       = reg_sel(addr);
  assign wr_bits   = wdata[NUM_LEDS-1:0];
  assign period_wr = wr && (sel == REG_PERIOD);
  assign led       = out_q;
  assign unused    = ^{addr[1:0], wdata};

  blink_timer #(
    .CNT_W (CNT_W)
  ) u_blink_timer (
    .sys_clk (sys_clk),
    .reset   (reset),
    .period  (period_q),
    .clear   (period_wr),
    .count   (count),
    .tick    (tick)
  );

  // Tick XOR stacks on SET/CLR/TOG results, but a direct OUT store wins outright.
  always_comb begin
    out_next = out_q;
    if (wr) begin
      case (sel)
        REG_SET: out_next = out_q | wr_bits;
        REG_CLR: out_next = out_q & ~wr_bits;
        REG_TOG: out_next = out_q ^ wr_bits;
        default: out_next = out_q;
      endcase
    end
    if (tick) begin
      out_next = out_next ^ mask_q;
    end
    if (wr && sel == REG_OUT) begin
      out_next = wr_bits;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      out_q    <= '0;
      mask_q   <= '0;
      period_q <= '0;
    end else begin
      out_q <= out_next;
      if (wr && sel == REG_BLINK_MASK) begin
        mask_q <= wr_bits;
      end
      if (period_wr) begin
        period_q <= wdata[CNT_W-1:0];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (sel)
        REG_OUT:        rdata = 32'(out_q);
        REG_BLINK_MASK: rdata = 32'(mask_q);
        REG_PERIOD:     rdata = 32'(period_q);
        REG_COUNT:      rdata = 32'(count);
        default:        rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_led_ctrl.sv
// Bench for mmio_led_ctrl (NUM_LEDS=4, CNT_W=8): vector table, directed blink corners, random traffic vs. model.
module tb_mmio_led_ctrl;

  localparam int NL = 4;
  localparam int CW = 8;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic          sys_clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_write = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic          hit;
  logic [31:0]   rdata;
  logic [NL-1:0] led;

  mmio_led_ctrl #(
    .BASE_ADDR (BASE),
    .NUM_LEDS  (NL),
    .CNT_W     (CW)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .hit       (hit),
    .rdata     (rdata),
    .led       (led)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference state: counter is derived from cycles elapsed since the last clear.
  int unsigned m_out = 0, m_mask = 0, m_period = 0, m_phase = 0;

  function automatic int unsigned m_count();
    return (m_period == 0) ? 0 : (m_phase % (m_period + 1));
  endfunction

  function automatic bit m_tick();
    return (m_period != 0) && (m_count() == m_period);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return (a / 32) == (BASE / 32);
  endfunction

  function automatic int unsigned m_rdata(input logic [31:0] a);
    int unsigned off;
    off = a % 32 - a % 4;
    if (!m_hit(a)) return 0;
    case (off)
      0:       return m_out;
      16:      return m_mask;
      20:      return m_period;
      24:      return m_count();
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int unsigned off, n, d;
    bit w, t;
    if (reset) begin
      m_out = 0; m_mask = 0; m_period = 0; m_phase = 0;
      return;
    end
    off = addr % 32 - addr % 4;
    d   = wdata;
    w   = mem_write && m_hit(addr);
    t   = m_tick() && !(w && off == 20);
    n   = m_out;
    if (w) begin
      case (off)
        4:       n = n | (d % 16);
        8:       n = n & ~(d % 16) & 15;
        12:      n = n ^ (d % 16);
        default: ;
      endcase
    end
    if (t) n = n ^ m_mask;
    if (w && off == 0) n = d % 16;
    if (w && off == 16) m_mask = d % 16;
    if (w && off == 20) begin
      m_period = d % 256;
      m_phase  = 0;
    end else begin
      m_phase++;
    end
    m_out = n;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Apply one cycle of inputs, compare combinational outputs to the model, then clock.
  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    reset = r; mem_write = w; addr = a; wdata = d;
    #1;
    check("model_hit", 32'(hit), 32'(m_hit(a)));
    check("model_rdata", rdata, m_rdata(a));
    check("model_led", 32'(led), m_out);
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
  endtask

  task automatic peek(input logic [31:0] a);
    reset = 1'b0; mem_write = 1'b0; addr = a; wdata = '0;
    #1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd_addr;
    logic [31:0] exp_led;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];
  int   exp_cnt[5] = '{0, 1, 2, 3, 0};
  int   exp_blk[5] = '{0, 0, 0, 0, 1};

  initial begin
    vecs[0]  = '{"out_store",    BASE + 32'h00, 32'h0000_000A, BASE + 32'h00, 32'hA, 32'hA};
    vecs[1]  = '{"set",          BASE + 32'h04, 32'h0000_0001, BASE + 32'h04, 32'hB, 32'h0};
    vecs[2]  = '{"clr",          BASE + 32'h08, 32'h0000_0008, BASE + 32'h08, 32'h3, 32'h0};
    vecs[3]  = '{"tog",          BASE + 32'h0C, 32'h0000_000F, BASE + 32'h0C, 32'hC, 32'h0};
    vecs[4]  = '{"out_wide",     BASE + 32'h00, 32'hFFFF_FFF5, BASE + 32'h00, 32'h5, 32'h5};
    vecs[5]  = '{"mask_wide",    BASE + 32'h10, 32'hFFFF_FFF3, BASE + 32'h10, 32'h5, 32'h3};
    vecs[6]  = '{"count_ro",     BASE + 32'h18, 32'h0000_0055, BASE + 32'h18, 32'h5, 32'h0};
    vecs[7]  = '{"reserved",     BASE + 32'h1C, 32'h0000_000F, BASE + 32'h1C, 32'h5, 32'h0};
    vecs[8]  = '{"out_of_win",   BASE + 32'h20, 32'h0000_0000, BASE + 32'h20, 32'h5, 32'h0};
    vecs[9]  = '{"byte_offset",  BASE + 32'h03, 32'h0000_000F, BASE + 32'h01, 32'hF, 32'hF};
    vecs[10] = '{"mask_clear",   BASE + 32'h12, 32'h0000_0000, BASE + 32'h10, 32'hF, 32'h0};

    drive(1'b1, 1'b0, BASE, '0);
    drive(1'b1, 1'b1, BASE, 32'hF);
    peek(BASE + 32'h00); check("rst_led", 32'(led), 0); check("rst_out", rdata, 0);
    peek(BASE + 32'h10); check("rst_mask", rdata, 0);
    peek(BASE + 32'h14); check("rst_period", rdata, 0);
    peek(BASE + 32'h18); check("rst_count", rdata, 0);

    foreach (vecs[i]) begin
      drive(1'b0, 1'b1, vecs[i].addr, vecs[i].wdata);
      peek(vecs[i].rd_addr);
      check({vecs[i].name, "_led"}, 32'(led), vecs[i].exp_led);
      check({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
    end

    // Blink with period 3: count 0..3, led[0] flips every 4 cycles.
    drive(1'b1, 1'b0, BASE, '0);
    drive(1'b0, 1'b1, BASE + 32'h10, 32'h1);
    drive(1'b0, 1'b1, BASE + 32'h00, 32'h0);
    drive(1'b0, 1'b1, BASE + 32'h14, 32'h3);
    for (int k = 0; k < 5; k++) begin
      peek(BASE + 32'h18);
      check($sformatf("blink_count%0d", k), rdata, exp_cnt[k]);
      check($sformatf("blink_led%0d", k), 32'(led), exp_blk[k]);
      drive(1'b0, 1'b0, BASE + 32'h18, '0);
    end
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, BASE, '0);
    peek(BASE + 32'h18);
    check("blink_back_off", 32'(led), 0);
    check("blink_count_wrap", rdata, 0);

    // OUT store on the tick cycle beats the blink toggle.
    drive(1'b0, 1'b1, BASE + 32'h14, 32'h3);
    drive(1'b0, 1'b1, BASE + 32'h10, 32'hF);
    drive(1'b0, 1'b0, BASE, '0);
    drive(1'b0, 1'b0, BASE, '0);
    peek(BASE + 32'h18); check("tick_cycle_count", rdata, 3);
    drive(1'b0, 1'b1, BASE + 32'h00, 32'h5);
    peek(BASE + 32'h00); check("out_on_tick", 32'(led), 32'h5);

    // TOG on the tick cycle stacks with the blink toggle.
    drive(1'b0, 1'b1, BASE + 32'h14, 32'h3);
    drive(1'b0, 1'b1, BASE + 32'h10, 32'h2);
    drive(1'b0, 1'b1, BASE + 32'h00, 32'h0);
    drive(1'b0, 1'b0, BASE, '0);
    drive(1'b0, 1'b1, BASE + 32'h0C, 32'h1);
    peek(BASE + 32'h00); check("tog_on_tick", 32'(led), 32'h3);

    // PERIOD store on the tick cycle: no toggle, counter restarts.
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, BASE, '0);
    drive(1'b0, 1'b1, BASE + 32'h14, 32'h3);
    peek(BASE + 32'h18);
    check("period_on_tick_led", 32'(led), 32'h3);
    check("period_on_tick_count", rdata, 0);

    // Reset mid-count stops blinking for good.
    drive(1'b0, 1'b0, BASE, '0);
    drive(1'b0, 1'b0, BASE, '0);
    drive(1'b1, 1'b0, BASE, '0);
    peek(BASE + 32'h18);
    check("midrst_led", 32'(led), 0);
    check("midrst_count", rdata, 0);
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, BASE + 32'h18, '0);
      check($sformatf("midrst_quiet%0d", k), 32'(led), 0);
    end
    peek(BASE + 32'h20); check("miss_hit", 32'(hit), 0); check("miss_rdata", rdata, 0);
    drive(1'b0, 1'b1, BASE + 32'h20, 32'hF);
    peek(BASE + 32'h00); check("miss_out", rdata, 0); check("miss_led", 32'(led), 0);
    peek(BASE + 32'h10); check("miss_mask", rdata, 0);

    for (int k = 0; k < 3000; k++) begin
      logic [31:0] a, d;
      logic r, w;
      r = ($urandom_range(0, 99) == 0);
      w = ($urandom_range(0, 1) == 1);
      a = ($urandom_range(0, 9) == 0) ? $urandom : (BASE | 32'($urandom_range(0, 31)));
      d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
      drive(r, w, a, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
